// File: rtl/sirv_reset_req_gen.sv
// -----------------------------------------------------------------------------
// sirv_reset_req_gen
//
// Source end of the reset path. Collects reset requests from software (keyed
// strobe), the watchdog (level) and the debug module (ndmreset level) and turns
// them into one clean, stretched, active-high reset request for the per-domain
// catch-and-sync stages. Also records which sources caused the reset and keeps
// a saturating count of reset events for diagnostics. Lives in the always-on
// domain.
//
// Ports:
//   clock        always-on clock
//   reset        synchronous, active-high reset
//   test_mode    scan/test mode; forces rst_req_out low (FSM keeps running)
//   sw_req_valid single-cycle software reset strobe
//   sw_req_key   key qualifying sw_req_valid; must equal SW_KEY
//   wdog_req     watchdog reset request (level)
//   dbg_req      debug ndmreset request (level)
//   cause_clr    single-cycle clear of cause and req_count
//   rst_req_out  active-high reset request to downstream stages
//   busy         high whenever the FSM is not IDLE
//   cause        sticky request causes {dbg, wdog, sw}
//   req_count    saturating count of reset events
// -----------------------------------------------------------------------------
module sirv_reset_req_gen #(
  parameter int unsigned STRETCH_CYCLES = 16,  // >= 1
  parameter int unsigned HOLDOFF_CYCLES = 8,   // 0 skips HOLDOFF
  parameter int unsigned CNT_W          = 8,   // holds max(STRETCH, HOLDOFF)
  parameter logic [7:0]  SW_KEY         = 8'h5A
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       test_mode,
  input  logic       sw_req_valid,
  input  logic [7:0] sw_req_key,
  input  logic       wdog_req,
  input  logic       dbg_req,
  input  logic       cause_clr,
  output logic       rst_req_out,
  output logic       busy,
  output logic [2:0] cause,
  output logic [7:0] req_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam bit             HAS_HOLDOFF  = (HOLDOFF_CYCLES != 0);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
    CNT_W'(HAS_HOLDOFF ? (HOLDOFF_CYCLES - 1) : 0);
  localparam logic [7:0]     COUNT_MAX    = 8'hFF;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic       sw_hit;   // software strobe carrying the correct key
  logic [2:0] src;      // per-source activity this cycle, {dbg, wdog, sw}
  logic       trig;
  logic       lvl;

  assign sw_hit = sw_req_valid && (sw_req_key == SW_KEY);
  assign src    = {dbg_req, wdog_req, sw_hit};
  assign trig   = |src;
  // Only level sources can extend the pulse; the sw strobe is one cycle wide.
  assign lvl    = wdog_req || dbg_req;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             rst_req_q,   rst_req_d;
  logic             busy_q,      busy_d;
  logic [2:0]       cause_q,     cause_d;
  logic [7:0]       req_count_q, req_count_d;

  logic [2:0]       cause_set;
  logic             count_inc;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_set = 3'b000;
    count_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d   = ST_ASSERT;
          cnt_d     = STRETCH_LOAD;
          cause_set = src;
          count_inc = 1'b1;
        end
      end

      ST_ASSERT: begin
        // Late requests are recorded but neither counted nor allowed to
        // restart the stretch.
        cause_set = src;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!lvl) begin
          if (HAS_HOLDOFF) begin
            state_d = ST_HOLDOFF;
            cnt_d   = HOLDOFF_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        // counter==0 with a level request still high: hold here with the
        // counter parked at 0 so the level is never released early.
      end

      ST_HOLDOFF: begin
        // Everything is ignored while the downstream stages settle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Clear first, then set: a source firing in the clear cycle keeps its bit.
    cause_d = (cause_clr ? 3'b000 : cause_q) | cause_set;

    if (cause_clr) begin
      req_count_d = count_inc ? 8'd1 : 8'd0;
    end else if (count_inc && (req_count_q != COUNT_MAX)) begin
      req_count_d = req_count_q + 8'd1;
    end else begin
      req_count_d = req_count_q;
    end

    // Outputs are decoded from the next state so they register with it.
    rst_req_d = (state_d == ST_ASSERT);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rst_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      cause_q     <= 3'b000;
      req_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_req_q   <= rst_req_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
      req_count_q <= req_count_d;
    end
  end

  // Test mode gates the request combinationally so the downstream stage sees
  // only the test reset; the FSM and diagnostics keep running underneath.
  assign rst_req_out = rst_req_q && !test_mode;
  assign busy        = busy_q;
  assign cause       = cause_q;
  assign req_count   = req_count_q;

endmodule

// File: tb/tb_sirv_reset_req_gen.sv
// -----------------------------------------------------------------------------
// tb_sirv_reset_req_gen
//
// Directed bench for sirv_reset_req_gen with default parameters
// (STRETCH=16, HOLDOFF=8, SW_KEY=8'h5A). Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, away from the active edge.
// Sample index 0 below is the sample just after the edge that saw the trigger.
// -----------------------------------------------------------------------------
module tb_sirv_reset_req_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       test_mode;
  logic       sw_req_valid;
  logic [7:0] sw_req_key;
  logic       wdog_req;
  logic       dbg_req;
  logic       cause_clr;
  logic       rst_req_out;
  logic       busy;
  logic [2:0] cause;
  logic [7:0] req_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  sirv_reset_req_gen dut (
    .clock        (clock),
    .reset        (reset),
    .test_mode    (test_mode),
    .sw_req_valid (sw_req_valid),
    .sw_req_key   (sw_req_key),
    .wdog_req     (wdog_req),
    .dbg_req      (dbg_req),
    .cause_clr    (cause_clr),
    .rst_req_out  (rst_req_out),
    .busy         (busy),
    .cause        (cause),
    .req_count    (req_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    sw_req_valid = 1'b0;
    sw_req_key   = 8'h00;
    wdog_req     = 1'b0;
    dbg_req      = 1'b0;
    cause_clr    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    test_mode = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    if (busy !== 1'b0) check("wait_idle timeout busy", busy, 0);
  endtask

  initial begin
    clear_inputs();
    test_mode = 1'b0;
    reset     = 1'b1;
    step();
    step();
    // Reset state
    check("reset rst_req_out", rst_req_out, 0);
    check("reset busy",        busy,        0);
    check("reset cause",       cause,       0);
    check("reset req_count",   req_count,   0);
    reset = 1'b0;

    // 1) Valid software strobe: 16 cycles high, 24 cycles busy.
    for (int i = 0; i < 8; i++) step();
    sw_req_valid = 1'b1;
    sw_req_key   = 8'h5A;
    step();
    clear_inputs();
    for (int i = 0; i < 30; i++) begin
      check($sformatf("sw rst_req_out @%0d", i), rst_req_out, (i < 16) ? 1 : 0);
      check($sformatf("sw busy @%0d", i),        busy,        (i < 24) ? 1 : 0);
      step();
    end
    check("sw cause",     cause,     3'b001);
    check("sw req_count", req_count, 1);

    // 2) Wrong key is ignored entirely.
    do_reset();
    sw_req_valid = 1'b1;
    sw_req_key   = 8'hA5;
    step();
    clear_inputs();
    check("badkey rst_req_out", rst_req_out, 0);
    check("badkey busy",        busy,        0);
    step();
    check("badkey cause",       cause,       0);
    check("badkey req_count",   req_count,   0);

    // 3) dbg_req level held for 40 edges: pulse tracks the level, then holdoff.
    do_reset();
    dbg_req = 1'b1;
    step();
    for (int i = 0; i < 56; i++) begin
      check($sformatf("dbg rst_req_out @%0d", i), rst_req_out, (i < 40) ? 1 : 0);
      check($sformatf("dbg busy @%0d", i),        busy,        (i < 48) ? 1 : 0);
      dbg_req = (i + 1 <= 39);
      step();
    end
    check("dbg cause",     cause,     3'b100);
    check("dbg req_count", req_count, 1);

    // 4) wdog + sw together, sw again in ASSERT, sw + dbg during HOLDOFF.
    do_reset();
    wdog_req     = 1'b1;
    sw_req_valid = 1'b1;
    sw_req_key   = 8'h5A;
    step();
    clear_inputs();
    for (int i = 0; i < 30; i++) begin
      check($sformatf("multi rst_req_out @%0d", i), rst_req_out, (i < 16) ? 1 : 0);
      check($sformatf("multi busy @%0d", i),        busy,        (i < 24) ? 1 : 0);
      clear_inputs();
      if (i == 4 || i == 19) begin
        sw_req_valid = 1'b1;
        sw_req_key   = 8'h5A;
      end
      if (i == 19) dbg_req = 1'b1;
      step();
    end
    clear_inputs();
    check("multi cause",     cause,     3'b011);
    check("multi req_count", req_count, 1);

    // 5a) cause_clr together with a valid sw trigger; set wins for sw only.
    do_reset();
    wdog_req = 1'b1;
    dbg_req  = 1'b1;
    step();
    clear_inputs();
    wait_idle(40);
    check("preclr cause",     cause,     3'b110);
    check("preclr req_count", req_count, 1);
    cause_clr    = 1'b1;
    sw_req_valid = 1'b1;
    sw_req_key   = 8'h5A;
    step();
    clear_inputs();
    check("clr+trig cause",     cause,     3'b001);
    check("clr+trig req_count", req_count, 1);
    wait_idle(40);
    cause_clr = 1'b1;
    step();
    clear_inputs();
    check("clr cause",     cause,     0);
    check("clr req_count", req_count, 0);

    // 5b) 300 events saturate the counter at 255.
    do_reset();
    for (int e = 1; e <= 300; e++) begin
      wdog_req = 1'b1;
      step();
      wdog_req = 1'b0;
      wait_idle(40);
      if (e == 254) check("sat count 254", req_count, 254);
      if (e == 255) check("sat count 255", req_count, 255);
    end
    check("sat count 300", req_count, 255);

    // 6a) test_mode: output gated, FSM and cause still run.
    do_reset();
    test_mode = 1'b1;
    wdog_req  = 1'b1;
    step();
    wdog_req = 1'b0;
    for (int i = 0; i < 28; i++) begin
      check($sformatf("tm rst_req_out @%0d", i), rst_req_out, 0);
      check($sformatf("tm busy @%0d", i),        busy,        (i < 24) ? 1 : 0);
      step();
    end
    check("tm cause",     cause,     3'b010);
    check("tm req_count", req_count, 1);
    test_mode = 1'b0;

    // 6b) reset mid-ASSERT aborts on the next edge.
    wdog_req = 1'b1;
    step();
    wdog_req = 1'b0;
    step();
    step();
    check("abort pre rst_req_out", rst_req_out, 1);
    reset = 1'b1;
    step();
    check("abort rst_req_out", rst_req_out, 0);
    check("abort busy",        busy,        0);
    check("abort cause",       cause,       0);
    check("abort req_count",   req_count,   0);
    reset = 1'b0;
    step();
    check("abort stays idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sirv_reset_req_gen.md
Name: sirv_reset_req_gen

Overview:
- Source end of the reset path: collects reset requests from software, the watchdog and the debug module.
- Turns them into one clean, stretched, active-high reset request pulse. This pulse feeds the reset input of the per-domain reset catch-and-sync stages.
- Records which sources caused the reset and counts reset events for diagnostics.
- Sits in the always-on domain and is clocked by the always-on clock.

Parameters:
- STRETCH_CYCLES, 16, minimum cycles rst_req_out stays high per event; must be >= 1.
- HOLDOFF_CYCLES, 8, cycles after release during which new requests are ignored; 0 skips the HOLDOFF state.
- CNT_W, 8, width of the internal cycle counter; must hold max(STRETCH_CYCLES, HOLDOFF_CYCLES).
- SW_KEY, 8'h5A, key value required for a software request to be accepted.

Ports:
- clock  input  1  always-on clock.
- reset  input  1  synchronous, active-high reset.
- test_mode  input  1  scan/test mode; forces rst_req_out low.
- sw_req_valid  input  1  single-cycle software reset request strobe.
- sw_req_key  input  8  key qualifying sw_req_valid.
- wdog_req  input  1  watchdog reset request, level.
- dbg_req  input  1  debug ndmreset request, level.
- cause_clr  input  1  single-cycle clear of cause and req_count.
- rst_req_out  output  1  active-high reset request to downstream catch-and-sync stages.
- busy  output  1  high in any state other than IDLE.
- cause  output  3  sticky request causes, {dbg, wdog, sw}.
- req_count  output  8  saturating count of reset events.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, rst_req_out=0, busy=0, cause=0, req_count=0. Asserting reset in any state aborts immediately to these values on the next edge.
- Trigger (trig) = (sw_req_valid && sw_req_key==SW_KEY) || wdog_req || dbg_req. A software strobe with the wrong key is ignored: no trigger, no cause bit, no count.
- Level request (lvl) = wdog_req || dbg_req.
- State IDLE:
  - If trig is sampled at edge N, go to ASSERT and load counter = STRETCH_CYCLES-1.
  - Set the cause bits of every source active in that cycle; simultaneous sources are ORed.
  - req_count += 1, saturating at 255.
  - rst_req_out goes high from cycle N+1 (registered, one-cycle latency).
- State ASSERT:
  - rst_req_out=1; the counter decrements each cycle.
  - When counter==0 and lvl==0: go to HOLDOFF with counter = HOLDOFF_CYCLES-1, or go straight to IDLE if HOLDOFF_CYCLES==0.
  - When counter==0 and lvl==1: stay in ASSERT with counter held at 0 until lvl drops, so that a level request is never released early.
  - Minimum high time is exactly STRETCH_CYCLES cycles.
  - Additional triggers during ASSERT OR their cause bits into cause but do not increment req_count and do not restart the counter.
- State HOLDOFF:
  - rst_req_out=0; the counter decrements; go to IDLE when counter==0.
  - All requests are ignored here: no cause update, no count.
  - A level request still high on return to IDLE retriggers in the first IDLE cycle.
- busy = (state != IDLE), registered alongside the state.
- cause_clr:
  - Clears cause and req_count.
  - If a cause set occurs in the same cycle, set wins for that bit; other bits clear.
  - If a counted trigger occurs in the same cycle, req_count becomes 1.
- test_mode=1:
  - rst_req_out is forced to 0 combinationally, so the downstream stage uses the test reset.
  - The FSM, cause and req_count keep operating normally.
- Counter arithmetic is unsigned CNT_W bits; no wrap is possible given the parameter constraints.

Test Plan:
- Release reset, then pulse sw_req_valid with sw_req_key=8'h5A at cycle 10 -> rst_req_out high cycles 11..26 (16 cycles), busy high 11..34, cause=3'b001, req_count=1.
- Pulse sw_req_valid with sw_req_key=8'hA5 -> rst_req_out stays 0, cause=0, req_count=0.
- Hold dbg_req high for 40 cycles from cycle 5 -> rst_req_out high 6..45 (tracks the level past STRETCH), then 8 HOLDOFF cycles, cause=3'b100, req_count=1.
- Assert wdog_req and a valid sw strobe in the same cycle, then a second sw strobe during ASSERT and a third during HOLDOFF -> single 16-cycle pulse, cause=3'b011, req_count=1.
- Assert cause_clr in the same cycle as a valid sw trigger with cause=3'b110 beforehand -> cause=3'b001, req_count=1. Separately, 300 events -> req_count saturates at 255.
- Set test_mode=1 and fire wdog_req -> rst_req_out stays 0, busy high for 24 cycles, cause=3'b010. Assert reset mid-ASSERT -> all outputs 0 on the next edge.
